// File: rtl/mlcd_bus_ctrl.sv
// Avalon-MM slave that queues LCD command/data words and paces 8080-style write strobes.
// Define MLCD_READ_EN to add a hardware LCD read cycle on a read of address 1.
module mlcd_bus_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned RST_WRL    = 2,
   parameter int unsigned RST_WRH    = 2,
   parameter int unsigned RST_SETUP  = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic        read_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        waitrequest,
   output logic        lcd_cs_n,
   output logic        lcd_rs,
   output logic        lcd_wr_n,
   output logic        lcd_rd_n,
   output logic        lcd_rst_n,
   output logic [15:0] lcd_data_out,
   output logic        lcd_data_oe,
   input  logic [15:0] lcd_data_in
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_WR_LO,
      S_WR_HI,
      S_RSETUP,
      S_RD_LO,
      S_RD_HI
   } state_t;

   state_t        state, state_nx;
   logic [7:0]    cnt, cnt_nx;
   logic [7:0]    tim_wrl, tim_wrh, tim_setup;
   logic [7:0]    lat_wrl, lat_wrh;
   logic [16:0]   mem [FIFO_DEPTH];
   logic [LW-1:0] wr_ptr, rd_ptr, level;
   logic [16:0]   head;
   logic          empty, full, busy;
   logic          push_req, push, pop, tim_latch;
   logic          cs_n_nx, wr_n_nx;
   logic          unused_ok;

   function automatic logic [7:0] fmax(input logic [7:0] f);
      return (f == 8'd0) ? 8'd1 : f;
   endfunction

   assign level    = wr_ptr - rd_ptr;
   assign empty    = (level == '0);
   assign full     = (level == LW'(FIFO_DEPTH));
   assign head     = mem[rd_ptr[AW-1:0]];
   assign busy     = (state != S_IDLE) | ~empty;
   assign push_req = chipselect & ~write_n & ~address[1];
   assign push     = push_req & (~full | pop);
   assign unused_ok = ^{writedata[31:24], lcd_data_in, read_n};

`ifdef MLCD_READ_EN
   logic        rd_req, rd_done, rd_start, rd_sample, rd_fin;
   logic        rd_n_nx, oe_nx;
   logic [15:0] rd_data;
   assign rd_req      = chipselect & ~read_n & (address == 2'd1);
   assign waitrequest = (push_req & full & ~pop) | (rd_req & ~rd_done);
`else
   assign waitrequest = push_req & full & ~pop;
   assign lcd_rd_n    = 1'b1;
   assign lcd_data_oe = 1'b1;
`endif

   // FIFO storage; flushing on reset is done by the pointers alone
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {address[0], writedata[15:0]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + LW'(1);
         if (pop)  rd_ptr <= rd_ptr + LW'(1);
      end
   end

   // Software-visible timing and panel-reset registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tim_wrl   <= 8'(RST_WRL);
         tim_wrh   <= 8'(RST_WRH);
         tim_setup <= 8'(RST_SETUP);
         lcd_rst_n <= 1'b0;
      end else if (chipselect && !write_n) begin
         if (address == 2'd2) begin
            tim_wrl   <= writedata[7:0];
            tim_wrh   <= writedata[15:8];
            tim_setup <= writedata[23:16];
         end
         if (address == 2'd3) lcd_rst_n <= writedata[0];
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      pop       = 1'b0;
      tim_latch = 1'b0;
`ifdef MLCD_READ_EN
      rd_start  = 1'b0;
      rd_sample = 1'b0;
      rd_fin    = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               tim_latch = 1'b1;
               cnt_nx    = fmax(tim_setup);
               state_nx  = S_SETUP;
`ifdef MLCD_READ_EN
            end else if (rd_req && !rd_done) begin
               rd_start  = 1'b1;
               tim_latch = 1'b1;
               cnt_nx    = fmax(tim_setup);
               state_nx  = S_RSETUP;
`endif
            end
         end
         S_SETUP: begin
            if (cnt == 8'd1) begin
               cnt_nx   = lat_wrl;
               state_nx = S_WR_LO;
            end else cnt_nx = cnt - 8'd1;
         end
         S_WR_LO: begin
            if (cnt == 8'd1) begin
               cnt_nx   = lat_wrh;
               state_nx = S_WR_HI;
            end else cnt_nx = cnt - 8'd1;
         end
         S_WR_HI: begin
            if (cnt == 8'd1) begin
               if (!empty) begin
                  pop       = 1'b1;
                  tim_latch = 1'b1;
                  cnt_nx    = fmax(tim_setup);
                  state_nx  = S_SETUP;
               end else state_nx = S_IDLE;
            end else cnt_nx = cnt - 8'd1;
         end
`ifdef MLCD_READ_EN
         S_RSETUP: begin
            if (cnt == 8'd1) begin
               cnt_nx   = lat_wrl;
               state_nx = S_RD_LO;
            end else cnt_nx = cnt - 8'd1;
         end
         S_RD_LO: begin
            if (cnt == 8'd1) begin
               rd_sample = 1'b1;
               cnt_nx    = lat_wrh;
               state_nx  = S_RD_HI;
            end else cnt_nx = cnt - 8'd1;
         end
         S_RD_HI: begin
            if (cnt == 8'd1) begin
               rd_fin   = 1'b1;
               state_nx = S_IDLE;
            end else cnt_nx = cnt - 8'd1;
         end
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   // Strobes are registered decodes of the next state
   assign cs_n_nx = (state_nx == S_IDLE);
   assign wr_n_nx = (state_nx != S_WR_LO);
`ifdef MLCD_READ_EN
   assign rd_n_nx = (state_nx != S_RD_LO);
   assign oe_nx   = !((state_nx == S_RSETUP) || (state_nx == S_RD_LO) || (state_nx == S_RD_HI));
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         cnt          <= 8'd0;
         lat_wrl      <= 8'd1;
         lat_wrh      <= 8'd1;
         lcd_cs_n     <= 1'b1;
         lcd_wr_n     <= 1'b1;
         lcd_rs       <= 1'b1;
         lcd_data_out <= 16'h0000;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         lcd_cs_n <= cs_n_nx;
         lcd_wr_n <= wr_n_nx;
         if (tim_latch) begin
            lat_wrl <= fmax(tim_wrl);
            lat_wrh <= fmax(tim_wrh);
         end
         if (pop) {lcd_rs, lcd_data_out} <= head;
`ifdef MLCD_READ_EN
         else if (rd_start) lcd_rs <= 1'b1;
`endif
      end
   end

`ifdef MLCD_READ_EN
   // Read-cycle strobes and the handshake that releases the stalled master
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lcd_rd_n    <= 1'b1;
         lcd_data_oe <= 1'b1;
         rd_done     <= 1'b0;
         rd_data     <= 16'h0000;
      end else begin
         lcd_rd_n    <= rd_n_nx;
         lcd_data_oe <= oe_nx;
         if (rd_sample) rd_data <= lcd_data_in;
         if (rd_fin) rd_done <= 1'b1;
         else if (rd_req && rd_done) rd_done <= 1'b0;
      end
   end
`endif

   always_comb begin
      readdata = '0;
      case (address)
`ifdef MLCD_READ_EN
         2'd1: readdata = {16'h0000, rd_data};
`endif
         2'd2: readdata = {8'h00, tim_setup, tim_wrh, tim_wrl};
         2'd3: readdata = {19'h0, 5'(level), 5'h0, full, busy, lcd_rst_n};
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_mlcd_bus_ctrl.sv
// Bench for mlcd_bus_ctrl: directed scenarios plus random bursts against a word/timing scoreboard.
// Pin monitor measures strobe phases and compares them with the per-word timing model.
module tb_mlcd_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect, write_n, read_n;
   logic [31:0] writedata, readdata;
   logic        waitrequest;
   logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n, lcd_data_oe;
   logic [15:0] lcd_data_out, lcd_data_in;

   always #5 clk = ~clk;

   mlcd_bus_ctrl #(.FIFO_DEPTH(4), .RST_WRL(2), .RST_WRH(2), .RST_SETUP(1)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
      .waitrequest(waitrequest), .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n),
      .lcd_rd_n(lcd_rd_n), .lcd_rst_n(lcd_rst_n), .lcd_data_out(lcd_data_out),
      .lcd_data_oe(lcd_data_oe), .lcd_data_in(lcd_data_in)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: expected words with the timing in force when each was queued
   typedef struct {
      logic        rs;
      logic [15:0] data;
      int          su;
      int          wl;
      int          wh;
   } word_t;

   word_t exp_q[$];
   int    t_su = 1, t_wl = 2, t_wh = 2;
   logic  m_rst = 1'b0;

   function automatic int fmax(input logic [7:0] f);
      return (f == 8'd0) ? 1 : int'(f);
   endfunction

   // Pin monitor: phase 0 idle, 1 cs low/wr high, 2 wr low, 3 read cycle
   int    phase = 0, run = 0, prev_wh = 0, sess_len = 0, last_sess = 0;
   int    falls = 0, sessions = 0, rd_pulses = 0, rd_run = 0;
   logic  first = 1'b1;
   word_t cur;

   always @(negedge clk) begin
      int np;
      if (!reset_n) begin
         phase = 0; run = 0; first = 1'b1; rd_run = 0;
      end else begin
         np = lcd_cs_n ? 0 : (!lcd_data_oe ? 3 : (!lcd_wr_n ? 2 : 1));
         if (np == phase) run++;
         else begin
            case (phase * 4 + np)
               6: begin
                  falls++;
                  if (exp_q.size() == 0) chk("extra_word", 32'd1, 32'd0);
                  else begin
                     cur = exp_q.pop_front();
                     chk("word", 32'({lcd_rs, lcd_data_out}), 32'({cur.rs, cur.data}));
                     chk("setup_gap", run, first ? cur.su : prev_wh + cur.su);
                  end
                  first = 1'b0;
               end
               9: begin
                  chk("wrl", run, cur.wl);
                  chk("word_hold", 32'({lcd_rs, lcd_data_out}), 32'({cur.rs, cur.data}));
                  prev_wh = cur.wh;
               end
               4: begin
                  if (first) chk("empty_session", 32'd1, 32'd0);
                  else chk("wrh_end", run, prev_wh);
                  last_sess = sess_len;
               end
               1: begin sessions++; first = 1'b1; sess_len = 0; end
               3: chk("rd_rs", 32'(lcd_rs), 32'd1);
               12: chk("rd_oe_len", run, t_su + t_wl + t_wh);
               default: chk("phase_seq", 32'(phase * 4 + np), 32'd0);
            endcase
            phase = np;
            run   = 1;
         end
         if (np == 1 || np == 2) sess_len++;
         if (!lcd_rd_n) rd_run++;
         else if (rd_run > 0) begin
            rd_pulses++;
            chk("rdl", rd_run, t_wl);
            rd_run = 0;
         end
      end
   end

   // Bus tasks start and end one time unit after a rising edge
   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, output int stalls);
      word_t w;
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d; stalls = 0;
      @(negedge clk);
      while (waitrequest && stalls < 200) begin stalls++; @(negedge clk); end
      if (waitrequest) chk("wr_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      case (a)
         2'd0, 2'd1: begin
            w.rs = a[0]; w.data = d[15:0]; w.su = t_su; w.wl = t_wl; w.wh = t_wh;
            exp_q.push_back(w);
         end
         2'd2: begin t_wl = fmax(d[7:0]); t_wh = fmax(d[15:8]); t_su = fmax(d[23:16]); end
         default: m_rst = d[0];
      endcase
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d, output int stalls);
      address = a; chipselect = 1'b1; read_n = 1'b0; stalls = 0;
      @(negedge clk);
      while (waitrequest && stalls < 200) begin stalls++; @(negedge clk); end
      if (waitrequest) chk("rd_timeout", 32'd1, 32'd0);
      d = readdata;
      @(posedge clk); #1;
      chipselect = 1'b0; read_n = 1'b1;
   endtask

   task automatic wait_idle();
      logic [31:0] d;
      int s, n;
      n = 0;
      bus_rd(2'd3, d, s);
      while (d[1] && n < 400) begin bus_rd(2'd3, d, s); n++; end
      chk("idle_reached", 32'(d[1]), 32'd0);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   initial begin
      logic [31:0] d, tv;
      int s, f0, s0, r0, n, g;
      int st[6];
      reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
      writedata = '0; lcd_data_in = 16'h0000;
      #12;
      chk("rst_pins", 32'({lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n, lcd_data_oe, waitrequest}),
          32'(7'b1111010));
      chk("rst_data", 32'(lcd_data_out), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      bus_rd(2'd3, d, s);
      chk("stat_reset", d, 32'h0);
      bus_wr(2'd3, 32'h1, s);
      bus_rd(2'd3, d, s);
      chk("stat_rstn", d, 32'h1);
      chk("lcd_rst_pin", 32'(lcd_rst_n), 32'(m_rst));

      // single command word with default timing
      f0 = falls;
      bus_wr(2'd0, 32'h0000_002C, s);
      bus_rd(2'd3, d, s);
      chk("busy_set", 32'(d[1]), 32'd1);
      wait_idle();
      bus_rd(2'd3, d, s);
      chk("stat_idle", d, 32'h1);
      chk("cmd_cycles", last_sess, 5);
      chk("cmd_words", falls - f0, 1);
      chk("idle_hold", 32'({lcd_rs, lcd_data_out}), 32'h0002C);

      // burst deeper than the FIFO
      f0 = falls; s0 = sessions;
      for (int i = 0; i < 6; i++) bus_wr(2'd1, 32'(i + 1), st[i]);
      chk("burst_nostall", st[0] + st[1] + st[2] + st[3], 0);
      chk("burst_stall6", 32'(st[5] > 0), 32'd1);
      wait_idle();
      chk("burst_words", falls - f0, 6);
      chk("burst_sessions", sessions - s0, 1);
      chk("burst_cycles", last_sess, 30);

      // programmed timing, zero fields, and a retime during a transfer
      bus_wr(2'd2, 32'h0002_0304, s);
      bus_wr(2'd1, 32'h0000_F800, s);
      wait_idle();
      chk("tim9_cycles", last_sess, 9);
      bus_wr(2'd2, 32'h0, s);
      bus_wr(2'd1, 32'h0000_1234, s);
      wait_idle();
      chk("tim0_cycles", last_sess, 3);
      bus_wr(2'd2, 32'h0001_0202, s);
      bus_wr(2'd1, 32'h0000_000A, s);
      bus_wr(2'd2, 32'h0, s);
      bus_wr(2'd1, 32'h0000_000B, s);
      wait_idle();
      chk("retime_cycles", last_sess, 8);

      // random bursts with random idle-time timing changes
      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            tv = {8'($urandom), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 4))};
            bus_wr(2'd2, tv, s);
            bus_rd(2'd2, d, s);
            chk("tim_rb", d, tv & 32'h00FF_FFFF);
         end
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            bus_wr(2'($urandom_range(0, 1)), $urandom, s);
            g = $urandom_range(0, 3);
            repeat (g) begin @(posedge clk); #1; end
         end
         wait_idle();
         chk("rand_drain", exp_q.size(), 0);
      end

      // reset in the middle of a long WR low phase with the FIFO full
      bus_wr(2'd2, 32'h0001_0208, s);
      for (int i = 0; i < 5; i++) bus_wr(2'd0, 32'(16'h0100 + i), s);
      bus_rd(2'd3, d, s);
      chk("stat_full", d, 32'h0000_0407);
      n = 0;
      while (lcd_wr_n && n < 50) begin @(negedge clk); n++; end
      chk("wr_low_seen", 32'(lcd_wr_n), 32'd0);
      #2 reset_n = 1'b0;
      #1 chk("rst_async", 32'({lcd_cs_n, lcd_wr_n, lcd_rst_n}), 32'(3'b110));
      exp_q.delete();
      t_su = 1; t_wl = 2; t_wh = 2; m_rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      f0 = falls;
      bus_rd(2'd3, d, s);
      chk("stat_flushed", d, 32'h0);
      repeat (30) begin @(posedge clk); #1; end
      chk("no_strobes", falls - f0, 0);

`ifdef MLCD_READ_EN
      lcd_data_in = 16'h5A5A;
      r0 = rd_pulses; f0 = falls;
      bus_wr(2'd1, 32'h0000_0077, s);
      bus_rd(2'd1, d, s);
      chk("rd_data", d, 32'h0000_5A5A);
      chk("rd_stalled", 32'(s > 0), 32'd1);
      chk("rd_pulses", rd_pulses - r0, 1);
      chk("rd_write_first", falls - f0, 1);
      chk("oe_after", 32'(lcd_data_oe), 32'd1);
`else
      r0 = rd_pulses;
      bus_rd(2'd1, d, s);
      chk("rd1_zero", d, 32'h0);
      chk("rd1_nostall", s, 0);
      chk("rd_pins", 32'({lcd_rd_n, lcd_data_oe}), 32'(2'b11));
      chk("rd_no_pulse", rd_pulses - r0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
